// File: rtl/sdc_escaped_bus_pkg.sv
// sdc_escaped_bus_pkg: shared constants, FSM states and lane-array type for the escaped-bus skid stage
package sdc_escaped_bus_pkg;
   localparam int LANES = 4;
   localparam int LANE_W_DEF = 4;
   localparam int CNT_W_DEF = 8;
   typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
   typedef logic [LANES-1:0][LANE_W_DEF-1:0] lanes_t;
endpackage

// File: rtl/sdc_escaped_bus_skid_if.sv
// sdc_escaped_bus_skid_if: valid/ready lane bus for the skid stage; out_parity exists only with SDC_ESCAPED_BUS_PARITY_EN
interface sdc_escaped_bus_skid_if import sdc_escaped_bus_pkg::*; #(
   parameter int LANE_W = LANE_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic in_valid, in_ready, out_valid, out_ready;
   logic [LANE_W-1:0] in_lane0, in_lane1, in_lane2, in_lane3;
   logic [LANE_W-1:0] out_lane0, out_lane1, out_lane2, out_lane3;
   logic [CNT_W-1:0] xfer_count;
`ifdef SDC_ESCAPED_BUS_PARITY_EN
   logic [LANES-1:0] out_parity;
   modport slave (
      input in_valid, in_lane0, in_lane1, in_lane2, in_lane3, out_ready,
      output in_ready, out_valid, out_lane0, out_lane1, out_lane2, out_lane3, xfer_count, out_parity
   );
   modport master (
      output in_valid, in_lane0, in_lane1, in_lane2, in_lane3, out_ready,
      input in_ready, out_valid, out_lane0, out_lane1, out_lane2, out_lane3, xfer_count, out_parity
   );
`else
   modport slave (
      input in_valid, in_lane0, in_lane1, in_lane2, in_lane3, out_ready,
      output in_ready, out_valid, out_lane0, out_lane1, out_lane2, out_lane3, xfer_count
   );
   modport master (
      output in_valid, in_lane0, in_lane1, in_lane2, in_lane3, out_ready,
      input in_ready, out_valid, out_lane0, out_lane1, out_lane2, out_lane3, xfer_count
   );
`endif
endinterface

// File: rtl/sdc_escaped_bus_lane_reg.sv
// sdc_escaped_bus_lane_reg: one lane-wide register with async reset and load enable
module sdc_escaped_bus_lane_reg import sdc_escaped_bus_pkg::*; #(
   parameter int W = LANE_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // capture d on load, clear immediately on reset
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (load) q <= d;
endmodule

// File: rtl/sdc_escaped_bus_skid.sv
// sdc_escaped_bus_skid: registered 2-entry skid stage for four bus lanes with transfer counter; SDC_ESCAPED_BUS_PARITY_EN adds per-lane parity
module sdc_escaped_bus_skid import sdc_escaped_bus_pkg::*; #(
   parameter int LANE_W = LANE_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic clk,
   input logic rst,
   sdc_escaped_bus_skid_if.slave bus
);
   typedef logic [LANES-1:0][LANE_W-1:0] lane_arr_t;
   state_t state_q, state_d;
   logic rdy_q, in_fire, out_fire, load_out, load_skid, sel_skid;
   logic [CNT_W-1:0] cnt_q;
   lane_arr_t in_arr, skid_q, out_q, out_d;
   assign in_arr = {bus.in_lane3, bus.in_lane2, bus.in_lane1, bus.in_lane0};
   assign bus.out_valid = state_q == BUSY || state_q == FULL;
   assign bus.in_ready = rdy_q;
   assign in_fire = bus.in_valid && rdy_q;
   assign out_fire = bus.out_valid && bus.out_ready;
   assign out_d = sel_skid ? skid_q : in_arr;
   assign bus.out_lane0 = out_q[0];
   assign bus.out_lane1 = out_q[1];
   assign bus.out_lane2 = out_q[2];
   assign bus.out_lane3 = out_q[3];
   assign bus.xfer_count = cnt_q;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sdc_escaped_bus_lane_reg #(.W(LANE_W)) u_out (.clk, .rst, .load(load_out), .d(out_d[i]), .q(out_q[i]));
      sdc_escaped_bus_lane_reg #(.W(LANE_W)) u_skid (.clk, .rst, .load(load_skid), .d(in_arr[i]), .q(skid_q[i]));
   end
`ifdef SDC_ESCAPED_BUS_PARITY_EN
   logic [LANES-1:0] in_par, out_par_d, out_par_q, skid_par_q;
   for (genvar i = 0; i < LANES; i++) begin : g_par
      assign in_par[i] = ^in_arr[i];
   end
   assign out_par_d = sel_skid ? skid_par_q : in_par;
   sdc_escaped_bus_lane_reg #(.W(LANES)) u_par_out (.clk, .rst, .load(load_out), .d(out_par_d), .q(out_par_q));
   sdc_escaped_bus_lane_reg #(.W(LANES)) u_par_skid (.clk, .rst, .load(load_skid), .d(in_par), .q(skid_par_q));
   assign bus.out_parity = out_par_q;
`endif
   // next state and register loads; the unused encoding behaves as EMPTY
   always_comb begin
      state_d = EMPTY;
      load_out = 1'b0;
      load_skid = 1'b0;
      sel_skid = 1'b0;
      case (state_q)
         BUSY: begin
            load_out = in_fire && out_fire;
            load_skid = in_fire && !out_fire;
            state_d = in_fire ? (out_fire ? BUSY : FULL) : (out_fire ? EMPTY : BUSY);
         end
         FULL: begin
            load_out = out_fire;
            sel_skid = 1'b1;
            state_d = out_fire ? BUSY : FULL;
         end
         default: begin
            load_out = in_fire;
            state_d = in_fire ? BUSY : EMPTY;
         end
      endcase
   end
   // state, registered in_ready (low only while FULL) and output transfer counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= EMPTY;
         rdy_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         rdy_q <= state_d != FULL;
         cnt_q <= cnt_q + CNT_W'(out_fire);
      end
endmodule

// File: tb/tb_sdc_escaped_bus_skid.sv
// tb_sdc_escaped_bus_skid: randomized and directed checks against a 2-deep FIFO reference model
module tb_sdc_escaped_bus_skid;
   import sdc_escaped_bus_pkg::*;
   localparam int CNT_W = CNT_W_DEF;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   lanes_t mq[$];
   bit m_ready = 1'b0;
   int m_cnt = 0;
   sdc_escaped_bus_skid_if bus ();
   sdc_escaped_bus_skid dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic lanes_t mk(logic [3:0] a0, logic [3:0] a1, logic [3:0] a2, logic [3:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic lanes_t cur_in();
      return {bus.in_lane3, bus.in_lane2, bus.in_lane1, bus.in_lane0};
   endfunction

   function automatic lanes_t cur_out();
      return {bus.out_lane3, bus.out_lane2, bus.out_lane1, bus.out_lane0};
   endfunction

   function automatic logic [3:0] par_of(lanes_t l);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ^l[i];
      return p;
   endfunction

   function automatic logic [63:0] obs();
      logic [63:0] v = '0;
      v[0] = bus.out_valid;
      v[1] = bus.in_ready;
      v[9:2] = bus.xfer_count;
      if (bus.out_valid) v[25:10] = cur_out();
`ifdef SDC_ESCAPED_BUS_PARITY_EN
      if (bus.out_valid) v[29:26] = bus.out_parity;
`endif
      return v;
   endfunction

   function automatic logic [63:0] expv();
      logic [63:0] v = '0;
      v[0] = mq.size() > 0;
      v[1] = m_ready;
      v[9:2] = 8'(m_cnt);
      if (mq.size() > 0) v[25:10] = mq[0];
`ifdef SDC_ESCAPED_BUS_PARITY_EN
      if (mq.size() > 0) v[29:26] = par_of(mq[0]);
`endif
      return v;
   endfunction

   task automatic drive(bit v, lanes_t l);
      bus.in_valid = v;
      {bus.in_lane3, bus.in_lane2, bus.in_lane1, bus.in_lane0} = l;
   endtask

   task automatic tick();
      bit fi, fo;
      lanes_t d;
      fi = bus.in_valid && m_ready;
      fo = mq.size() > 0 && bus.out_ready;
      d = cur_in();
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_ready = 1'b0;
         m_cnt = 0;
      end else begin
         if (fo) void'(mq.pop_front());
         if (fi) mq.push_back(d);
         m_ready = mq.size() < 2;
         if (fo) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.out_ready = 1'b0;
      drive(1'b1, mk(4'hF, 4'hF, 4'hF, 4'hF));
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if ({bus.out_valid, bus.in_ready, bus.xfer_count, cur_out()} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got v=%b r=%b cnt=%h lanes=%h want all zero", bus.out_valid, bus.in_ready, bus.xfer_count, cur_out());
         end
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: got r=%b v=%b want r=1 v=0", bus.in_ready, bus.out_valid);
      end
      drive(1'b0, '0);
   endtask

   task automatic test_single();
      bus.out_ready = 1'b1;
      drive(1'b1, mk(4'h1, 4'h2, 4'h3, 4'h4));
      tick();
      drive(1'b0, '0);
      n_cmp++;
      if ({bus.out_valid, cur_out()} !== {1'b1, 16'h4321}) begin
         n_err++;
         $display("FAIL single_out: got v=%b lanes=%h want v=1 lanes=4321", bus.out_valid, cur_out());
      end
      tick();
      n_cmp++;
      if ({bus.out_valid, bus.xfer_count} !== {1'b0, 8'd1}) begin
         n_err++;
         $display("FAIL single_done: got v=%b cnt=%0d want v=0 cnt=1", bus.out_valid, bus.xfer_count);
      end
   endtask

   task automatic test_skid();
      int c0 = m_cnt;
      bus.out_ready = 1'b0;
      drive(1'b1, mk(4'hA, 4'hA, 4'hA, 4'hA));
      tick();
      drive(1'b1, mk(4'hB, 4'hB, 4'hB, 4'hB));
      tick();
      drive(1'b0, '0);
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, cur_out()} !== {1'b0, 1'b1, 16'hAAAA}) begin
         n_err++;
         $display("FAIL skid_full: got r=%b v=%b lanes=%h want r=0 v=1 lanes=aaaa", bus.in_ready, bus.out_valid, cur_out());
      end
      tick();
      n_cmp++;
      if (cur_out() !== 16'hAAAA || obs() !== expv()) begin
         n_err++;
         $display("FAIL skid_hold: got lanes=%h vec=%h want lanes=aaaa vec=%h", cur_out(), obs(), expv());
      end
      bus.out_ready = 1'b1;
      tick();
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, cur_out()} !== {1'b1, 1'b1, 16'hBBBB}) begin
         n_err++;
         $display("FAIL skid_second: got v=%b r=%b lanes=%h want v=1 r=1 lanes=bbbb", bus.out_valid, bus.in_ready, cur_out());
      end
      tick();
      n_cmp++;
      if ({bus.out_valid, bus.xfer_count} !== {1'b0, 8'(c0 + 2)}) begin
         n_err++;
         $display("FAIL skid_drain: got v=%b cnt=%0d want v=0 cnt=%0d", bus.out_valid, bus.xfer_count, c0 + 2);
      end
   endtask

   task automatic test_stream();
      lanes_t l;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 4; i++) l[i] = 4'((k + i) % 16);
         drive(1'b1, l);
         tick();
         n_cmp++;
         if ({bus.out_valid, cur_out()} !== {1'b1, l} || obs() !== expv()) begin
            n_err++;
            $display("FAIL stream_%0d: got v=%b lanes=%h want v=1 lanes=%h", k, bus.out_valid, cur_out(), l);
         end
      end
      drive(1'b0, '0);
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 1)), lanes_t'($urandom));
         bus.out_ready = 1'($urandom_range(0, 3) != 0);
         tick();
         n_cmp++;
         if (obs() !== expv()) begin
            n_err++;
            $display("FAIL random_%0d: got %h want %h", k, obs(), expv());
         end
      end
      drive(1'b0, '0);
      bus.out_ready = 1'b1;
      repeat (3) tick();
   endtask

`ifdef SDC_ESCAPED_BUS_PARITY_EN
   task automatic test_parity();
      bus.out_ready = 1'b1;
      drive(1'b1, mk(4'h7, 4'h3, 4'h0, 4'hF));
      tick();
      drive(1'b0, '0);
      n_cmp++;
      if (bus.out_parity !== 4'b0001 || obs() !== expv()) begin
         n_err++;
         $display("FAIL parity: got %b want 0001", bus.out_parity);
      end
      tick();
   endtask
`endif

   task automatic test_mid_reset();
      bus.out_ready = 1'b0;
      drive(1'b1, mk(4'hA, 4'hA, 4'hA, 4'hA));
      tick();
      drive(1'b1, mk(4'hB, 4'hB, 4'hB, 4'hB));
      tick();
      drive(1'b0, '0);
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, cur_out()} !== {1'b0, 1'b1, 16'hAAAA}) begin
         n_err++;
         $display("FAIL midrst_full: got r=%b v=%b lanes=%h want r=0 v=1 lanes=aaaa", bus.in_ready, bus.out_valid, cur_out());
      end
      #2 rst = 1'b1;
      mq.delete();
      m_ready = 1'b0;
      m_cnt = 0;
      #1;
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.xfer_count, cur_out()} !== '0) begin
         n_err++;
         $display("FAIL midrst_async: got v=%b r=%b cnt=%h lanes=%h want all zero", bus.out_valid, bus.in_ready, bus.xfer_count, cur_out());
      end
      #2 rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b0 || obs() !== expv()) begin
            n_err++;
            $display("FAIL midrst_stale_%0d: got v=%b lanes=%h want v=0", k, bus.out_valid, cur_out());
         end
      end
   endtask

   task automatic test_wrap();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 257; k++) begin
         drive(1'b1, lanes_t'($urandom));
         tick();
      end
      drive(1'b0, '0);
      tick();
      n_cmp++;
      if (bus.xfer_count !== 8'd1 || obs() !== expv()) begin
         n_err++;
         $display("FAIL wrap: got cnt=%0d want 1", bus.xfer_count);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, '0);
      test_reset();
      test_single();
      test_skid();
      test_stream();
      test_random();
`ifdef SDC_ESCAPED_BUS_PARITY_EN
      test_parity();
`endif
      test_mid_reset();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
